trig_cfg_sequencer: RTL
=======================

TRIG_CFG_SEQUENCER -- requirements
Module: trig_cfg_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 cfg_wr  input  1  one-cycle write strobe for cfg_addr/cfg_data.
REQ-004 cfg_addr  input  5  shadow word address, 0..30 valid.
REQ-005 cfg_data  input  16  write data.
REQ-006 cfg_commit  input  1  one-cycle request to transfer shadow to active.
REQ-007 actv_feb_fg  input  1  trigger datapath activity flag.
REQ-008 HCmask  output  288  active hot-channel mask, 1 = channel enabled.
REQ-009 collmask  output  168  active collision pattern mask.
REQ-010 hmt_thresholds  output  30  active shower thresholds.
REQ-011 input_disr  output  1  datapath input disable, 1 = layer inputs forced to zero.
REQ-012 cfg_busy  output  1  high while the commit FSM is not in IDLE.
REQ-013 cfg_done  output  1  one-cycle pulse when a commit completes.
REQ-014 cfg_forced  output  1  sticky flag: last commit was taken on timeout.
REQ-015 cfg_err  output  1  sticky flag: rejected write, bad address or ignored commit.

Function
REQ-016 Shadow map: words 0..17 hold HCmask[16k+15:16k]; words 18..27 hold collmask[16k'+15:16k'] with k'=addr-18; word 28 bits 7:0 hold collmask[167:160], bits 15:8 ignored; word 29 holds hmt_thresholds[15:0]; word 30 bits 13:0 hold hmt_thresholds[29:16], bits 15:14 ignored.
REQ-017 In IDLE, cfg_wr with addr<=30 updates the shadow word on the same edge; addr=31 updates nothing and sets cfg_err.
REQ-018 cfg_wr outside IDLE updates nothing and sets cfg_err.
REQ-019 cfg_commit outside IDLE is ignored and sets cfg_err.
REQ-020 Active outputs change only in COPY; shadow writes never reach the outputs directly.
REQ-021 FSM states: IDLE, WAIT_QUIET, DISABLE, COPY, DRAIN, DONE.
REQ-022 IDLE -> WAIT_QUIET on cfg_commit; quiet counter and timeout counter clear.
REQ-023 WAIT_QUIET: quiet counter increments on each cycle actv_feb_fg=0 and clears on actv_feb_fg=1; -> DISABLE when the counter reaches 8, cfg_forced cleared.
REQ-024 WAIT_QUIET: 10-bit timeout counter increments every cycle; at 1023 with quiet<8 -> DISABLE, cfg_forced set.
REQ-025 If quiet reaches 8 and timeout reaches 1023 on the same cycle, the quiet exit wins and cfg_forced is cleared.
REQ-026 DISABLE: input_disr=1 for exactly 4 cycles, then -> COPY.
REQ-027 COPY: one cycle; all three active registers load from shadow together; input_disr=1; -> DRAIN.
REQ-028 DRAIN: input_disr=1 for exactly 16 cycles, then -> DONE.
REQ-029 DONE: one cycle; cfg_done=1; input_disr=0; -> IDLE.
REQ-030 input_disr=1 only in DISABLE, COPY and DRAIN; all outputs are registered.
REQ-031 Commit latency with actv_feb_fg held 0: cfg_commit at cycle T gives COPY at T+13 and cfg_done at T+30.
REQ-032 cfg_err clears only on reset; cfg_forced changes only on a commit exit from WAIT_QUIET.

Reset
REQ-033 rst_n=0 forces state IDLE, all counters 0, cfg_err=0, cfg_forced=0, cfg_done=0, input_disr=0.
REQ-034 rst_n=0 sets shadow and active HCmask to all ones, collmask to all ones, hmt_thresholds to 30'h3FFFFFFF.
REQ-035 Reset in the middle of a commit abandons the commit; the active registers take reset values, not shadow values.

Verification
REQ-036 After reset: write word 0=16'h0000, commit, actv_feb_fg=0 -> HCmask[15:0]=0 from T+13, rest ones, input_disr high T+9..T+29, cfg_done at T+30.
REQ-037 actv_feb_fg toggles 1/0 every 4 cycles through the commit -> timeout exit, DISABLE entered at 1023 cycles after entering WAIT_QUIET, cfg_forced=1, copy still occurs.
REQ-038 Write word 28=16'hFF5A and word 30=16'hC123 -> after commit collmask[167:160]=8'h5A, hmt_thresholds[29:16]=14'h0123.
REQ-039 cfg_wr and cfg_commit during DRAIN, plus cfg_wr to addr 31 in IDLE -> shadow unchanged, commit not restarted, cfg_err=1.
REQ-040 rst_n asserted during DRAIN after a write of word 5=0 -> outputs return to reset values, input_disr=0, no cfg_done.

Source files
------------

// File: rtl/trig_cfg_sequencer.sv
// Trigger configuration sequencer: shadow register file plus a commit FSM
// that waits for a quiet datapath (or times out), disables the layer inputs,
// copies shadow to active in one cycle and drains before releasing.
module trig_cfg_sequencer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_wr,
  input  logic [4:0]   cfg_addr,
  input  logic [15:0]  cfg_data,
  input  logic         cfg_commit,
  input  logic         actv_feb_fg,
  output logic [287:0] HCmask,
  output logic [167:0] collmask,
  output logic [29:0]  hmt_thresholds,
  output logic         input_disr,
  output logic         cfg_busy,
  output logic         cfg_done,
  output logic         cfg_forced,
  output logic         cfg_err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_QUIET,
    DISABLE,
    COPY,
    DRAIN,
    DONE
  } state_t;

  state_t       state, next_state;
  logic [3:0]   quiet_cnt, quiet_next;
  logic [9:0]   tmo_cnt, tmo_next;
  logic [3:0]   phase_cnt, phase_next;
  logic         quiet_exit;
  logic         wq_exit;
  logic         wr_ok;
  logic         err_set;

  logic [287:0] hc_shadow;
  logic [167:0] coll_shadow;
  logic [29:0]  hmt_shadow;

  // Writes land only in IDLE and never for the unmapped address 31.
  assign wr_ok   = cfg_wr && (state == IDLE) && (cfg_addr != 5'd31);
  assign err_set = (cfg_wr && ((state != IDLE) || (cfg_addr == 5'd31))) ||
                   (cfg_commit && (state != IDLE));

  // Next-state and counter logic; quiet exit takes priority over timeout.
  always_comb begin
    next_state = state;
    quiet_next = quiet_cnt;
    tmo_next   = tmo_cnt;
    phase_next = phase_cnt;
    quiet_exit = 1'b0;
    wq_exit    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_commit) begin
          next_state = WAIT_QUIET;
          quiet_next = 4'd0;
          tmo_next   = 10'd0;
        end
      end
      WAIT_QUIET: begin
        quiet_next = actv_feb_fg ? 4'd0 : quiet_cnt + 4'd1;
        tmo_next   = tmo_cnt + 10'd1;
        if (quiet_next == 4'd8) begin
          quiet_exit = 1'b1;
          wq_exit    = 1'b1;
          next_state = DISABLE;
          phase_next = 4'd0;
        end else if (tmo_next == 10'd1023) begin
          wq_exit    = 1'b1;
          next_state = DISABLE;
          phase_next = 4'd0;
        end
      end
      DISABLE: begin
        if (phase_cnt == 4'd3) begin
          next_state = COPY;
          phase_next = 4'd0;
        end else begin
          phase_next = phase_cnt + 4'd1;
        end
      end
      COPY: begin
        next_state = DRAIN;
        phase_next = 4'd0;
      end
      DRAIN: begin
        if (phase_cnt == 4'd15) begin
          next_state = DONE;
          phase_next = 4'd0;
        end else begin
          phase_next = phase_cnt + 4'd1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      quiet_cnt <= 4'd0;
      tmo_cnt   <= 10'd0;
      phase_cnt <= 4'd0;
    end else begin
      state     <= next_state;
      quiet_cnt <= quiet_next;
      tmo_cnt   <= tmo_next;
      phase_cnt <= phase_next;
    end
  end

  // Shadow register file, written word by word while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_shadow   <= '1;
      coll_shadow <= '1;
      hmt_shadow  <= 30'h3FFFFFFF;
    end else if (wr_ok) begin
      for (int k = 0; k < 18; k++) begin
        if (cfg_addr == 5'(k)) hc_shadow[16*k +: 16] <= cfg_data;
      end
      for (int k = 0; k < 10; k++) begin
        if (cfg_addr == 5'(k + 18)) coll_shadow[16*k +: 16] <= cfg_data;
      end
      if (cfg_addr == 5'd28) coll_shadow[167:160] <= cfg_data[7:0];
      if (cfg_addr == 5'd29) hmt_shadow[15:0]     <= cfg_data;
      if (cfg_addr == 5'd30) hmt_shadow[29:16]    <= cfg_data[13:0];
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HCmask         <= '1;
      collmask       <= '1;
      hmt_thresholds <= 30'h3FFFFFFF;
      input_disr     <= 1'b0;
      cfg_busy       <= 1'b0;
      cfg_done       <= 1'b0;
      cfg_forced     <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      if (next_state == COPY) begin
        HCmask         <= hc_shadow;
        collmask       <= coll_shadow;
        hmt_thresholds <= hmt_shadow;
      end
      input_disr <= (next_state == DISABLE) || (next_state == COPY) ||
                    (next_state == DRAIN);
      cfg_busy   <= (next_state != IDLE);
      cfg_done   <= (next_state == DONE);
      if (wq_exit) cfg_forced <= !quiet_exit;
      if (err_set) cfg_err <= 1'b1;
    end
  end

endmodule
